mdr_mem_if: RTL and testbench

MDR_MEM_IF -- requirements
Module: mdr_mem_if

---
 rtl/mdr_mem_if.sv | 172 +++++++++++++++++
 tb/tb_mdr_mem_if.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_if.sv
// Memory data register with a single-outstanding memory access port.
// Loads from the internal bus, reads memory with byte/half/word extraction
// and sign/zero extension, and writes lane-replicated data with byte enables.
// Every access is bounded by TIMEOUT wait cycles.
module mdr_mem_if #(
    parameter int BITS    = 32,
    parameter int TIMEOUT = 15,
    localparam int NLANE  = BITS / 8,
    localparam int OFFB   = $clog2(BITS / 8)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [BITS-1:0]   busMuxOut,
    input  logic              MDRin,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [OFFB-1:0]   offset,
    input  logic [BITS-1:0]   MDataIn,
    input  logic              mem_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [BITS-1:0]   MDataOut,
    output logic [NLANE-1:0]  mem_be,
    output logic [BITS-1:0]   MDRout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BITS-1:0]   mdr_q, mdr_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [OFFB-1:0]   off_q, off_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [7:0]        rd_b;
    logic [15:0]       rd_h;
    logic [BITS-1:0]   rd_ext;
    logic [BITS-1:0]   wr_data;
    logic [NLANE-1:0]  wr_be;

    // Read extraction: pick the addressed lane(s) of MDataIn, then extend.
    // Lane matching by loop keeps odd lane counts from indexing past BITS.
    always_comb begin
        rd_b   = '0;
        rd_h   = '0;
        rd_ext = '0;
        for (int l = 0; l < NLANE; l++) begin
            if (l == int'(off_q))
                rd_b = MDataIn[l*8 +: 8];
            if (l == (int'(off_q) & ~1))
                rd_h[7:0] = MDataIn[l*8 +: 8];
            if (l == (int'(off_q) & ~1) + 1)
                rd_h[15:8] = MDataIn[l*8 +: 8];
        end
        if (size_q[1]) begin
            rd_ext = MDataIn;
        end else if (size_q[0]) begin
            rd_ext       = {BITS{sign_q & rd_h[15]}};
            rd_ext[15:0] = rd_h;
        end else begin
            rd_ext      = {BITS{sign_q & rd_b[7]}};
            rd_ext[7:0] = rd_b;
        end
    end

    // Write formatting: replicate the low byte/half of MDR across lanes and
    // enable only the addressed lane(s); a half ignores offset bit 0.
    always_comb begin
        wr_data = '0;
        wr_be   = '0;
        for (int l = 0; l < NLANE; l++) begin
            if (size_q[1]) begin
                wr_data[l*8 +: 8] = mdr_q[l*8 +: 8];
                wr_be[l]          = 1'b1;
            end else if (size_q[0]) begin
                wr_data[l*8 +: 8] = (l % 2 == 0) ? mdr_q[7:0] : mdr_q[15:8];
                wr_be[l]          = (l == (int'(off_q) & ~1)) ||
                                    (l == (int'(off_q) & ~1) + 1);
            end else begin
                wr_data[l*8 +: 8] = mdr_q[7:0];
                wr_be[l]          = (l == int'(off_q));
            end
        end
    end

    // Next-state: IDLE arbitration (read > write > bus load), then wait for
    // ack or expire after TIMEOUT active cycles.
    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        size_d  = size_q;
        sign_d  = sign_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_start || wr_start) begin
                    state_d = rd_start ? READ : WRITE;
                    size_d  = size;
                    sign_d  = sign;
                    off_d   = offset;
                    cnt_d   = '0;
                end else if (MDRin) begin
                    mdr_d = busMuxOut;
                end
            end
            READ, WRITE: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (state_q == READ)
                        mdr_d = rd_ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; clear aborts any access silently.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd   = (state_q == READ);
    assign mem_wr   = (state_q == WRITE);
    assign busy     = (state_q != IDLE);
    assign MDataOut = (state_q == WRITE) ? wr_data : mdr_q;
    assign mem_be   = (state_q == WRITE) ? wr_be : '0;
    assign MDRout   = mdr_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Bench for mdr_mem_if (BITS=32, TIMEOUT=15): directed cases plus random
// transactions checked against an arithmetic model of the MDR.
module tb_mdr_mem_if;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] busMuxOut;
    logic        MDRin, rd_start, wr_start;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  offset;
    logic [31:0] MDataIn;
    logic        mem_ack;
    logic        mem_rd, mem_wr;
    logic [31:0] MDataOut;
    logic [3:0]  mem_be;
    logic [31:0] MDRout;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;
    logic [31:0] mdr_m = '0;

    mdr_mem_if #(.BITS(32), .TIMEOUT(TO)) dut (
        .clk(clk), .clear(clear), .busMuxOut(busMuxOut), .MDRin(MDRin),
        .rd_start(rd_start), .wr_start(wr_start), .size(size), .sign(sign),
        .offset(offset), .MDataIn(MDataIn), .mem_ack(mem_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .MDataOut(MDataOut), .mem_be(mem_be),
        .MDRout(MDRout), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: value a load leaves in the MDR.
    function automatic logic [31:0] model_read(logic [31:0] d, logic [1:0] sz,
                                               logic sg, logic [1:0] off);
        logic [31:0] v;
        int o;
        o = int'(off);
        if (sz >= 2) return d;
        if (sz == 1) begin
            v = (d >> ((o - (o % 2)) * 8)) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = (d >> (o * 8)) & 32'hFF;
            if (sg && v >= 32'h80) v = v - 32'h100;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] m, logic [1:0] sz);
        if (sz >= 2) return m;
        if (sz == 1) return (m & 32'hFFFF) * 32'h0001_0001;
        return (m & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [3:0] model_be(logic [1:0] sz, logic [1:0] off);
        int o;
        o = int'(off);
        if (sz >= 2) return 4'hF;
        if (sz == 1) return 4'(3 << (o - (o % 2)));
        return 4'(1 << o);
    endfunction

    task automatic idle_inputs();
        rd_start = 0; wr_start = 0; MDRin = 0; mem_ack = 0;
        size = 0; sign = 0; offset = 0;
    endtask

    // One access started at the current negedge; returns at the negedge
    // where done/err should be high, so the next call starts back-to-back.
    task automatic run_txn(input bit is_rd, input logic [1:0] sz, input bit sg,
                           input logic [1:0] off, input int ack_at,
                           input logic [31:0] din, input bit all3);
        logic [31:0] exp_mdr, exp_dout;
        logic [3:0]  exp_be;
        int cnt, exp_cnt;
        bit ok;
        ok       = (ack_at >= 1 && ack_at <= TO);
        exp_cnt  = ok ? ack_at : TO;
        exp_mdr  = (ok && is_rd) ? model_read(din, sz, sg, off) : mdr_m;
        exp_dout = model_wdata(mdr_m, sz);
        exp_be   = model_be(sz, off);
        rd_start  = is_rd;
        wr_start  = is_rd ? (all3 ? 1'b1 : 1'($urandom % 2)) : 1'b1;
        MDRin     = all3 ? 1'b1 : 1'($urandom % 2);
        busMuxOut = $urandom;
        size = sz; sign = sg; offset = off;
        MDataIn = $urandom;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL pulse_width: done=%b err=%b want 0 0", done, err);
        end
        cnt = 0;
        for (int c = 1; c <= TO + 2; c++) begin
            if (!(mem_rd || mem_wr)) break;
            cnt++;
            rd_start = 1'($urandom % 2); wr_start = 1'($urandom % 2);
            MDRin = 1'($urandom % 2); busMuxOut = $urandom;
            size = 2'($urandom); sign = 1'($urandom); offset = 2'($urandom);
            total++;
            if (mem_rd !== is_rd || mem_wr !== !is_rd || busy !== 1'b1 ||
                done !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL active_flags c=%0d: rd=%b wr=%b busy=%b done=%b err=%b want rd=%b",
                         c, mem_rd, mem_wr, busy, done, err, is_rd);
            end
            total++;
            if (is_rd ? (mem_be !== 4'h0 || MDataOut !== mdr_m)
                      : (mem_be !== exp_be || MDataOut !== exp_dout)) begin
                bad++;
                $display("FAIL bus_out c=%0d: be=%h dout=%h want be=%h dout=%h", c, mem_be,
                         MDataOut, is_rd ? 4'h0 : exp_be, is_rd ? mdr_m : exp_dout);
            end
            total++;
            if (MDRout !== mdr_m) begin
                bad++; $display("FAIL mdr_hold c=%0d: got %h want %h", c, MDRout, mdr_m);
            end
            mem_ack = (c == ack_at);
            MDataIn = (c == ack_at) ? din : $urandom;
            @(negedge clk);
            mem_ack = 0;
        end
        idle_inputs();
        total++;
        if (cnt != exp_cnt) begin
            bad++; $display("FAIL req_cycles: got %0d want %0d", cnt, exp_cnt);
        end
        total++;
        if (done !== ok || err !== !ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL completion: done=%b err=%b busy=%b want done=%b err=%b busy=0",
                     done, err, busy, ok, !ok);
        end
        total++;
        if (MDRout !== exp_mdr) begin
            bad++; $display("FAIL mdr_result: got %h want %h", MDRout, exp_mdr);
        end
        mdr_m = exp_mdr;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        MDRin = 1; busMuxOut = v;
        @(negedge clk);
        MDRin = 0;
        mdr_m = v;
        total++;
        if (MDRout !== v || busy !== 0 || mem_rd !== 0 || mem_wr !== 0) begin
            bad++;
            $display("FAIL mdr_load: mdr=%h busy=%b rd=%b wr=%b want %h 0 0 0",
                     MDRout, busy, mem_rd, mem_wr, v);
        end
    endtask

    task automatic test_reset();
        clear = 0; idle_inputs(); busMuxOut = 0; MDataIn = 0;
        #3;
        total++;
        if (MDRout !== 0 || MDataOut !== 0 || mem_be !== 0 || mem_rd !== 0 ||
            mem_wr !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
            bad++;
            $display("FAIL reset_state: mdr=%h dout=%h be=%h rd=%b wr=%b busy=%b done=%b err=%b want all 0",
                     MDRout, MDataOut, mem_be, mem_rd, mem_wr, busy, done, err);
        end
        @(negedge clk);
        clear = 1;
        mdr_m = 0;
    endtask

    task automatic test_mdrin();
        load_mdr(32'hDEADBEEF);
        total++;
        if (MDRout !== 32'hDEADBEEF) begin
            bad++; $display("FAIL mdrin_const: got %h want deadbeef", MDRout);
        end
    endtask

    task automatic test_read_byte();
        run_txn(1, 2'b00, 1, 2'd2, 4, 32'h12F45678, 0);
        total++;
        if (MDRout !== 32'hFFFFFFF4) begin
            bad++; $display("FAIL read_byte_sx: got %h want fffffff4", MDRout);
        end
        @(negedge clk);
        run_txn(1, 2'b00, 0, 2'd2, 4, 32'h12F45678, 0);
        total++;
        if (MDRout !== 32'h000000F4) begin
            bad++; $display("FAIL read_byte_zx: got %h want 000000f4", MDRout);
        end
        @(negedge clk);
    endtask

    task automatic test_write_half();
        load_mdr(32'h0000ABCD);
        run_txn(0, 2'b01, 0, 2'd2, 3, 32'h0, 0);
        total++;
        if (MDRout !== 32'h0000ABCD) begin
            bad++; $display("FAIL write_half_mdr: got %h want 0000abcd", MDRout);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        load_mdr(32'h13579BDF);
        run_txn(1, 2'b10, 0, 2'd0, 0, 32'hCAFEF00D, 0);
        @(negedge clk);
        run_txn(1, 2'b10, 0, 2'd0, TO, 32'hCAFEF00D, 0);
        total++;
        if (MDRout !== 32'hCAFEF00D) begin
            bad++; $display("FAIL last_cycle_ack: got %h want cafef00d", MDRout);
        end
        @(negedge clk);
        run_txn(0, 2'b00, 0, 2'd1, 0, 32'h0, 0);
        @(negedge clk);
    endtask

    task automatic test_idle_ack();
        mem_ack = 1;
        repeat (3) @(negedge clk);
        mem_ack = 0;
        total++;
        if (done !== 0 || err !== 0 || busy !== 0 || MDRout !== mdr_m) begin
            bad++;
            $display("FAIL idle_ack: done=%b err=%b busy=%b mdr=%h want 0 0 0 %h",
                     done, err, busy, MDRout, mdr_m);
        end
    endtask

    task automatic test_priority();
        load_mdr(32'h11111111);
        run_txn(1, 2'b01, 1, 2'd1, 2, 32'h8001_7FFF, 1);
        total++;
        if (MDRout !== 32'h00007FFF) begin
            bad++; $display("FAIL priority_read: got %h want 00007fff", MDRout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        load_mdr(32'hA5A5A5A5);
        rd_start = 0; wr_start = 1; size = 2'b10;
        @(negedge clk);
        wr_start = 0;
        @(negedge clk);
        #2 clear = 0;
        #1;
        total++;
        if (mem_wr !== 0 || busy !== 0 || MDRout !== 0 || MDataOut !== 0 ||
            mem_be !== 0 || done !== 0 || err !== 0) begin
            bad++;
            $display("FAIL reset_mid: wr=%b busy=%b mdr=%h dout=%h be=%h done=%b err=%b want all 0",
                     mem_wr, busy, MDRout, MDataOut, mem_be, done, err);
        end
        mdr_m = 0;
        @(negedge clk);
        clear = 1;
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        total++;
        if (done !== 0 || err !== 0 || busy !== 0) begin
            bad++; $display("FAIL post_reset: done=%b err=%b busy=%b want 0 0 0", done, err, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 4 == 0) begin
                load_mdr($urandom);
            end
            run_txn(1'($urandom % 2), 2'($urandom), 1'($urandom), 2'($urandom),
                    int'($urandom_range(0, TO)), $urandom, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mdrin();
        test_read_byte();
        test_write_half();
        test_timeout();
        test_idle_ack();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
